// File: rtl/alu_seq.sv
// Sequential ALU: captures operands on start, evaluates single-cycle ops in EXEC
// and unsigned multiply by shift-add in MUL, then pulses done for one cycle.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 use_acc,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_LOG = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_CAT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [2:0]      r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [RW-1:0]   r_result;
  logic [RW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [RW-1:0]   r_acc;
  logic [CW-1:0]   r_count;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_mul_last;
  logic [RW-1:0]    w_acc_next;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [RW-1:0]    w_a_ext;
  logic [31:0]      w_b32;
  logic [31:0]      w_shamt;
  logic [RW-1:0]    w_exec_res;

  // The accumulator feedback reads the result as it stands on the start edge.
  assign w_b_eff    = use_acc ? r_result[WIDTH-1:0] : b;
  assign w_mul_last = (r_count == CW'(WIDTH - 1));
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = r_a - r_b;
  assign w_a_ext = RW'(r_a);
  assign w_b32   = 32'(r_b);
  assign w_shamt = w_b32 % 32'(RW);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_exec_res = '0;
    case (r_op)
      OP_INC:  w_exec_res = w_a_ext + RW'(1);
      OP_ADD:  w_exec_res = RW'(w_sum);
      OP_SUB:  w_exec_res = {{WIDTH{w_diff[WIDTH-1]}}, w_diff};
      OP_LOG:  w_exec_res = {r_a | r_b, r_a ^ r_b};
      OP_ROR:  w_exec_res = RW'(|{r_a, r_b});
      OP_CAT:  w_exec_res = {r_a, r_b};
      OP_SHL:  w_exec_res = w_a_ext << w_shamt;
      default: w_exec_res = r_result;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC:  w_state_next = S_DONE;
      S_MUL: begin
        if (w_mul_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_a      <= a;
            r_b      <= w_b_eff;
            r_mcand  <= RW'(a);
            r_mplier <= w_b_eff;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_EXEC: begin
          r_result <= w_exec_res;
        end
        S_MUL: begin
          // Result is written only on the last partial product so it never shows a partial sum.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (w_mul_last) begin
            r_result <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;
  assign busy   = (r_state == S_EXEC) || (r_state == S_MUL);
  assign done   = (r_state == S_DONE);

endmodule
